// File: rtl/vga_pkg.sv
// Shared constants for the VGA PMOD dither path: Bayer thresholds,
// pipeline depth and the RGB field layout of the incoming pixel word.
package vga_pkg;

  // Phase counters, frame counter and thresholds are all this narrow.
  typedef logic [1:0] phase_t;
  typedef logic [3:0] thresh_t;

  // Cycles from any input to its aligned output (colour, de, hs, vs).
  localparam int PIPE_LATENCY = 2;

  // Channel field offsets inside {r[7:0], g[7:0], b[7:0]}.
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  localparam int CHAN_W = 8;
  localparam int NUM_CHAN = 3;

  // 4x4 ordered-dither thresholds, entry index = {row, col}, entry 0 at the LSB.
  // Rows (col 0..3): 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5
  localparam logic [63:0] BAYER_FLAT = {
    4'd5,  4'd13, 4'd7,  4'd15,
    4'd9,  4'd1,  4'd11, 4'd3,
    4'd6,  4'd14, 4'd4,  4'd12,
    4'd10, 4'd2,  4'd8,  4'd0
  };

  // Threshold for a given row (line phase) and column.
  function automatic thresh_t bayer_lookup(input phase_t row, input phase_t col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return BAYER_FLAT[base +: 4];
  endfunction

  // Channel 0 = red, 1 = green, 2 = blue.
  function automatic int channel_lsb(input int idx);
    case (idx)
      0:       return R_LSB;
      1:       return G_LSB;
      default: return B_LSB;
    endcase
  endfunction

endpackage

// File: rtl/vga_dither_channel.sv
// One colour channel of the second pipeline stage: adds the dither
// threshold, saturates at full scale, keeps the top 4 bits and blanks
// the result outside the display-enable window.
module vga_dither_channel
  import vga_pkg::*;
#(
  parameter bit DITHER_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    c,
  input  thresh_t       t,
  input  logic          de,
  output logic [3:0]    q
);

  logic [8:0] sum;
  logic [3:0] dith;
  logic [3:0] q_next;

  // Add threshold, clamp on carry-out so bright inputs never wrap to dark.
  always_comb begin
    sum    = {1'b0, c} + {5'b0, t};
    dith   = sum[8] ? 4'hF : sum[7:4];
    q_next = 4'h0;
    if (de) begin
      q_next = DITHER_EN ? dith : c[7:4];
    end
  end

  // Output register; reset flushes any in-flight colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 4'h0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/vga_pmod_dither.sv
// 24-bit VGA pixel stream to 12-bit PMOD DAC with 4x4 ordered dithering.
// Stage 1 captures the pixel with its threshold; stage 2 (per channel)
// dithers and registers the colour. de/hs/vs ride a matching delay line.
module vga_pmod_dither
  import vga_pkg::*;
#(
  parameter bit DITHER_EN        = 1'b1,
  parameter bit TEMPORAL_EN      = 1'b1,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_active,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [23:0] vga_pixel_rgb,
  output logic [3:0]  pmod_r,
  output logic [3:0]  pmod_g,
  output logic [3:0]  pmod_b,
  output logic        pmod_de,
  output logic        pmod_hs,
  output logic        pmod_vs
);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_HIGH ? 1'b0 : 1'b1;

  phase_t  x_phase_reg, x_phase_next;
  phase_t  y_phase_reg, y_phase_next;
  phase_t  frame_reg,   frame_next;
  logic    active_prev_reg;
  logic    vsync_prev_reg;
  logic    active_fall;
  logic    vsync_rise;
  phase_t  col;
  thresh_t t_now;

  logic [23:0] pixel_s1_reg;
  thresh_t     t_s1_reg;

  logic de_pipe_reg [PIPE_LATENCY];
  logic hs_pipe_reg [PIPE_LATENCY];
  logic vs_pipe_reg [PIPE_LATENCY];

  logic [3:0] chan_q [NUM_CHAN];

  // Edge detection and next-state of the phase/frame counters.
  // A vsync edge outranks a same-cycle line end so the frame starts on row 0.
  always_comb begin
    active_fall = active_prev_reg & ~vga_active;
    vsync_rise  = (vga_vsync != SYNC_IDLE) && (vsync_prev_reg == SYNC_IDLE);

    x_phase_next = vga_active ? phase_t'(x_phase_reg + 2'd1) : 2'd0;
    y_phase_next = y_phase_reg;
    frame_next   = frame_reg;
    if (vsync_rise) begin
      y_phase_next = 2'd0;
      frame_next   = phase_t'(frame_reg + 2'd1);
    end else if (active_fall) begin
      y_phase_next = phase_t'(y_phase_reg + 2'd1);
    end

    col   = TEMPORAL_EN ? phase_t'(x_phase_reg + frame_reg) : x_phase_reg;
    t_now = bayer_lookup(y_phase_reg, col);
  end

  // Phase/frame counters and the previous-cycle samples used for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_phase_reg     <= 2'd0;
      y_phase_reg     <= 2'd0;
      frame_reg       <= 2'd0;
      active_prev_reg <= 1'b0;
      vsync_prev_reg  <= SYNC_IDLE;
    end else begin
      x_phase_reg     <= x_phase_next;
      y_phase_reg     <= y_phase_next;
      frame_reg       <= frame_next;
      active_prev_reg <= vga_active;
      vsync_prev_reg  <= vga_vsync;
    end
  end

  // Stage 1: capture the pixel together with the threshold chosen for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_s1_reg <= 24'h0;
      t_s1_reg     <= 4'h0;
    end else begin
      pixel_s1_reg <= vga_pixel_rgb;
      t_s1_reg     <= t_now;
    end
  end

  // Control delay line; element 0 is stage 1, the last element drives the pins.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LATENCY; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        // First tap samples the timing-core inputs.
        always_ff @(posedge clk) begin
          if (reset) begin
            de_pipe_reg[gi] <= 1'b0;
            hs_pipe_reg[gi] <= SYNC_IDLE;
            vs_pipe_reg[gi] <= SYNC_IDLE;
          end else begin
            de_pipe_reg[gi] <= vga_active;
            hs_pipe_reg[gi] <= vga_hsync;
            vs_pipe_reg[gi] <= vga_vsync;
          end
        end
      end else begin : g_tail
        // Later taps shift the previous tap along.
        always_ff @(posedge clk) begin
          if (reset) begin
            de_pipe_reg[gi] <= 1'b0;
            hs_pipe_reg[gi] <= SYNC_IDLE;
            vs_pipe_reg[gi] <= SYNC_IDLE;
          end else begin
            de_pipe_reg[gi] <= de_pipe_reg[gi-1];
            hs_pipe_reg[gi] <= hs_pipe_reg[gi-1];
            vs_pipe_reg[gi] <= vs_pipe_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Stage 2: one dither slice per colour, gated by the stage-1 enable.
  generate
    for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
      localparam int LSB = channel_lsb(gi);
      vga_dither_channel #(
        .DITHER_EN (DITHER_EN)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .c     (pixel_s1_reg[LSB +: CHAN_W]),
        .t     (t_s1_reg),
        .de    (de_pipe_reg[0]),
        .q     (chan_q[gi])
      );
    end
  endgenerate

  assign pmod_r  = chan_q[0];
  assign pmod_g  = chan_q[1];
  assign pmod_b  = chan_q[2];
  assign pmod_de = de_pipe_reg[PIPE_LATENCY-1];
  assign pmod_hs = hs_pipe_reg[PIPE_LATENCY-1];
  assign pmod_vs = vs_pipe_reg[PIPE_LATENCY-1];

endmodule

// File: tb/tb_vga_pmod_dither.sv
// Directed bench: three instances (truncate, static dither, temporal
// dither) share one stimulus stream; each step's expectation is checked
// two clocks after the step is applied.
module tb_vga_pmod_dither;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vga_active = 1'b0;
  logic        vga_hsync = 1'b0;
  logic        vga_vsync = 1'b0;
  logic [23:0] vga_pixel_rgb = 24'h0;

  logic [3:0] tr_r, tr_g, tr_b, st_r, st_g, st_b, tp_r, tp_g, tp_b;
  logic       tr_de, tr_hs, tr_vs, st_de, st_hs, st_vs, tp_de, tp_hs, tp_vs;

  always #5 clk = ~clk;

  vga_pmod_dither #(.DITHER_EN(1'b0), .TEMPORAL_EN(1'b1), .SYNC_ACTIVE_HIGH(1'b1)) u_trunc (
    .clk(clk), .reset(reset), .vga_active(vga_active), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_pixel_rgb(vga_pixel_rgb),
    .pmod_r(tr_r), .pmod_g(tr_g), .pmod_b(tr_b),
    .pmod_de(tr_de), .pmod_hs(tr_hs), .pmod_vs(tr_vs));

  vga_pmod_dither #(.DITHER_EN(1'b1), .TEMPORAL_EN(1'b0), .SYNC_ACTIVE_HIGH(1'b1)) u_static (
    .clk(clk), .reset(reset), .vga_active(vga_active), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_pixel_rgb(vga_pixel_rgb),
    .pmod_r(st_r), .pmod_g(st_g), .pmod_b(st_b),
    .pmod_de(st_de), .pmod_hs(st_hs), .pmod_vs(st_vs));

  vga_pmod_dither #(.DITHER_EN(1'b1), .TEMPORAL_EN(1'b1), .SYNC_ACTIVE_HIGH(1'b1)) u_temporal (
    .clk(clk), .reset(reset), .vga_active(vga_active), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_pixel_rgb(vga_pixel_rgb),
    .pmod_r(tp_r), .pmod_g(tp_g), .pmod_b(tp_b),
    .pmod_de(tp_de), .pmod_hs(tp_hs), .pmod_vs(tp_vs));

  // One input step plus the {r,g,b} each instance should emit for it.
  typedef struct {
    logic        rst;
    logic        act;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [11:0] e_tr;
    logic [11:0] e_st;
    logic [11:0] e_tp;
  } vec_t;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [11:0] tr;
    logic [11:0] st;
    logic [11:0] tp;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_d1, exp_d2;
  bit   v1 = 1'b0, v2 = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  task automatic add(input logic rst, input logic act, input logic hs, input logic vs,
                     input logic [23:0] rgb, input logic [11:0] etr,
                     input logic [11:0] est, input logic [11:0] etp);
    vec_t v;
    v.rst = rst; v.act = act; v.hs = hs; v.vs = vs; v.rgb = rgb;
    v.e_tr = etr; v.e_st = est; v.e_tp = etp;
    tbl.push_back(v);
  endtask

  // Four active pixels of one line; st4/tp4 list expectations pixel 0 first.
  task automatic add_line(input logic [23:0] rgb, input logic [11:0] etr,
                          input logic [47:0] st4, input logic [47:0] tp4);
    for (int i = 0; i < 4; i++) begin
      add(1'b0, 1'b1, 1'b0, 1'b0, rgb, etr, st4[47-12*i -: 12], tp4[47-12*i -: 12]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got de/hs/vs=%b rgb=%h, required de/hs/vs=%b rgb=%h",
               name, step_no, got[14:12], got[11:0], want[14:12], want[11:0]);
    end
  endtask

  // Check outputs for the step applied two clocks ago, then drive this step.
  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    step_no++;
    if (v2) begin
      check("trunc",    {tr_de, tr_hs, tr_vs, tr_r, tr_g, tr_b}, {exp_d2.ctl, exp_d2.tr});
      check("static",   {st_de, st_hs, st_vs, st_r, st_g, st_b}, {exp_d2.ctl, exp_d2.st});
      check("temporal", {tp_de, tp_hs, tp_vs, tp_r, tp_g, tp_b}, {exp_d2.ctl, exp_d2.tp});
    end
    exp_d2 = exp_d1;
    v2     = v1;
    e.ctl  = {v.act, v.hs, v.vs};
    e.tr   = v.e_tr;
    e.st   = v.e_st;
    e.tp   = v.e_tp;
    exp_d1 = e;
    v1     = 1'b1;
    if (v.rst) begin
      // Reset empties both stages: the next two observations are idle.
      exp_d1 = '0;
      exp_d2 = '0;
      v2     = 1'b1;
    end
    reset         = v.rst;
    vga_active    = v.act;
    vga_hsync     = v.hs;
    vga_vsync     = v.vs;
    vga_pixel_rgb = v.rgb;
    $display("step %0d rst=%b de=%b hs=%b vs=%b rgb=%h", step_no, v.rst, v.act, v.hs, v.vs, v.rgb);
  endtask

  task automatic apply_now(input logic rst, input logic act, input logic hs,
                           input logic [23:0] rgb, input logic [11:0] etr,
                           input logic [11:0] est, input logic [11:0] etp);
    vec_t v;
    v.rst = rst; v.act = act; v.hs = hs; v.vs = 1'b0; v.rgb = rgb;
    v.e_tr = etr; v.e_st = est; v.e_tp = etp;
    apply(v);
  endtask

  initial begin
    // Reset with hsync driven high: outputs must stay idle.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 24'h123456, 12'h0, 12'h0, 12'h0);
    idle(2);
    // Line y=0 frame 0, r=08 -> 0,1,0,1...; g=00 -> 0; b=FF saturates to F.
    add_line(24'h0800FF, 12'h00F, {12'h00F, 12'h10F, 12'h00F, 12'h10F}, {12'h00F, 12'h10F, 12'h00F, 12'h10F});
    add_line(24'h0800FF, 12'h00F, {12'h00F, 12'h10F, 12'h00F, 12'h10F}, {12'h00F, 12'h10F, 12'h00F, 12'h10F});
    // Blanking with live pixel data and an hsync pulse: colour forced to 0.
    add(1'b0, 1'b0, 1'b0, 1'b0, 24'hA53CF0, 12'h0, 12'h0, 12'h0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 24'hA53CF0, 12'h0, 12'h0, 12'h0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 24'hA53CF0, 12'h0, 12'h0, 12'h0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 24'hA53CF0, 12'h0, 12'h0, 12'h0);
    // Line y=1: thresholds 12,4,14,6; truncation gives A,3,F.
    add_line(24'hA53CF0, 12'hA3F, {12'hB4F, 12'hA4F, 12'hB4F, 12'hA4F}, {12'hB4F, 12'hA4F, 12'hB4F, 12'hA4F});
    idle(2);
    // Line y=2: r=FA must saturate for every threshold.
    add_line(24'hFA00F0, 12'hF0F, {12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F}, {12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F});
    idle(2);
    // Line y=3: thresholds 15,7,13,5.
    add_line(24'h0810FA, 12'h01F, {12'h11F, 12'h01F, 12'h11F, 12'h01F}, {12'h11F, 12'h01F, 12'h11F, 12'h01F});
    // Vsync 1 -> frame 1: temporal columns start at 1 (t=8).
    idle(1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 12'h0, 12'h0, 12'h0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 12'h0, 12'h0, 12'h0);
    idle(1);
    add_line(24'h080000, 12'h000, {12'h000, 12'h100, 12'h000, 12'h100}, {12'h100, 12'h000, 12'h100, 12'h000});
    // Vsync 2 lands on the de fall: next line must be row 0, frame 2 (t=2 first).
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 12'h0, 12'h0, 12'h0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 12'h0, 12'h0, 12'h0);
    idle(1);
    add_line(24'h0E0000, 12'h000, {12'h000, 12'h100, 12'h100, 12'h100}, {12'h100, 12'h100, 12'h000, 12'h100});
    // Vsync 3 -> frame 3 (t=10 first).
    idle(1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 12'h0, 12'h0, 12'h0);
    idle(1);
    add_line(24'h080000, 12'h000, {12'h000, 12'h100, 12'h000, 12'h100}, {12'h100, 12'h000, 12'h100, 12'h000});
    // Vsync 4 -> frame wraps to 0.
    idle(1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 12'h0, 12'h0, 12'h0);
    idle(1);
    add_line(24'h080000, 12'h000, {12'h000, 12'h100, 12'h000, 12'h100}, {12'h000, 12'h100, 12'h000, 12'h100});
    idle(2);

    foreach (tbl[i]) apply(tbl[i]);

    // Mid-line reset on row 1: two pixels, one reset cycle, then the line
    // continues from x=0 on row 0 with nothing stale leaking out.
    apply_now(1'b0, 1'b1, 1'b0, 24'h080000, 12'h000, 12'h100, 12'h100);
    apply_now(1'b0, 1'b1, 1'b0, 24'h080000, 12'h000, 12'h000, 12'h000);
    apply_now(1'b1, 1'b1, 1'b1, 24'h080000, 12'h000, 12'h000, 12'h000);
    apply_now(1'b0, 1'b1, 1'b0, 24'h080000, 12'h000, 12'h000, 12'h000);
    apply_now(1'b0, 1'b1, 1'b0, 24'h080000, 12'h000, 12'h100, 12'h100);
    apply_now(1'b0, 1'b1, 1'b0, 24'h080000, 12'h000, 12'h000, 12'h000);
    apply_now(1'b0, 1'b1, 1'b0, 24'h080000, 12'h000, 12'h100, 12'h100);
    for (int i = 0; i < 3; i++) apply_now(1'b0, 1'b0, 1'b0, 24'h0, 12'h0, 12'h0, 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pmod_dither.md
VGA_PMOD_DITHER -- requirements
Module: vga_pmod_dither

Interface
REQ-001 Parameter DITHER_EN, default 1, enables ordered dithering; 0 selects plain truncation to the top 4 bits.
REQ-002 Parameter TEMPORAL_EN, default 1, rotates the dither pattern horizontally once per frame.
REQ-003 Parameter SYNC_ACTIVE_HIGH, default 1, gives the polarity of the hsync/vsync inputs and outputs.
REQ-004 clk  input  1  pixel clock (40 MHz dot clock); the block uses this one clock only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vga_active  input  1  data enable from the timing core.
REQ-007 vga_hsync  input  1  horizontal sync, polarity set by SYNC_ACTIVE_HIGH.
REQ-008 vga_vsync  input  1  vertical sync, polarity set by SYNC_ACTIVE_HIGH.
REQ-009 vga_pixel_rgb  input  24  pixel colour as {r[7:0], g[7:0], b[7:0]}.
REQ-010 pmod_r, pmod_g, pmod_b  output  4 each  dithered 12-bit colour for the dual-PMOD DAC.
REQ-011 pmod_de, pmod_hs, pmod_vs  output  1 each  enable and syncs, delayed to align with the colour outputs.

Function
REQ-012 Total latency from any input to the corresponding outputs SHALL be exactly 2 clk cycles for colour, de, hs and vs alike.
REQ-013 x_phase (2 bits): cleared on any cycle with vga_active=0; otherwise increments mod 4 each active cycle.
REQ-014 y_phase (2 bits): increments mod 4 on each falling edge of vga_active.
REQ-015 Vsync assertion edge (inactive-to-active per polarity): clears y_phase and increments frame (2 bits, wraps 3->0).
REQ-016 If the vsync assertion edge and a vga_active fall occur in the same cycle, the vsync clear SHALL win and y_phase SHALL become 0.
REQ-017 Threshold table, 4x4 Bayer indexed [row][col], row-major: 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5.
REQ-018 t = table[y_phase][col], where col = (x_phase + frame) mod 4 if TEMPORAL_EN=1, else col = x_phase.
REQ-019 Stage 1 SHALL register the pixel, t, de, hs and vs.
REQ-020 Stage 2 SHALL compute, per channel, the 9-bit sum c[7:0] + t and output sum[8] ? 4'hF : sum[7:4] (saturating), then register it.
REQ-021 With DITHER_EN=0, each channel output SHALL be c[7:4]; counters still run but are unused.
REQ-022 Colour outputs SHALL be forced to 0 on any cycle where the aligned pmod_de is 0.
REQ-023 pmod_hs and pmod_vs SHALL keep the input polarity, unmodified apart from the 2-cycle delay.
REQ-024 Input 8'hFF on any channel SHALL never wrap: the output is 4'hF for every t.
REQ-025 Input 8'h00 SHALL always output 4'h0.

Reset
REQ-026 While reset=1, at each clk edge: pmod_r/g/b=0 and pmod_de=0.
REQ-027 While reset=1, pmod_hs and pmod_vs SHALL be driven to their inactive level (0 if SYNC_ACTIVE_HIGH=1, else 1).
REQ-028 While reset=1, x_phase, y_phase, frame and all pipeline registers SHALL clear to zero/inactive.
REQ-029 Reset asserted mid-frame SHALL flush the pipeline within the same edge, with no stale pixel emerging afterwards.
REQ-030 After reset, counting SHALL resume from the next input cycle; phases realign naturally at the next vsync edge.

Structure
REQ-031 The Bayer table, the pipeline latency constant (2) and the RGB field offsets SHALL live in the shared package vga_pkg.
REQ-032 Per-channel add/saturate/truncate logic SHALL be one sub-module, vga_dither_channel, instantiated three times.
REQ-033 The phase/frame counters and sync delay line SHALL remain in vga_pmod_dither.

Verification
REQ-034 DITHER_EN=0, pixel 24'hA5_3C_F0 held with de=1 -> r=4'hA, g=4'h3, b=4'hF two cycles later; de/hs/vs delayed by exactly 2.
REQ-035 DITHER_EN=1, TEMPORAL_EN=0, r=8'h08, frame 0, line y_phase=0, de high 8 cycles -> r sequence 0,1,0,1,0,1,0,1 (t=0,8,2,10 repeating).
REQ-036 r=8'hFF and r=8'hFA across all 16 (x,y) phases -> r=4'hF every pixel; r=8'h00 -> always 4'h0.
REQ-037 TEMPORAL_EN=1 over three vsync pulses -> first-pixel t on row 0 follows 8, 2, 10 (col 1, 2, 3), and frame wraps to 0 after the 4th.
REQ-038 vsync assertion coincident with a de fall -> next line uses y_phase=0.
REQ-039 Reset pulsed for 1 cycle mid-line -> next two outputs are colour 0, de 0, syncs inactive, and x_phase restarts at 0.
